// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/result bundle between EX-stage control and alu_seq.
//               master = issuing side (drives request fields),
//               slave  = alu_seq (drives handshake ready, result and flags).
//   in_valid/in_ready        request handshake, accept = in_valid & in_ready
//   alu_op, data1, data2     opcode and operands (rs, rt)
//   out_valid                one-cycle result pulse
//   d_out, hi, lo            single-cycle result / mul-div result pair
//   zero_flag, exp_overflow, div_by_zero, illegal_op, busy   status
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             out_valid;
    logic [WIDTH-1:0] d_out;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero_flag;
    logic             exp_overflow;
    logic             div_by_zero;
    logic             illegal_op;
    logic             busy;

    modport master (
        output in_valid, alu_op, data1, data2,
        input  in_ready, out_valid, d_out, hi, lo,
               zero_flag, exp_overflow, div_by_zero, illegal_op, busy
    );

    modport slave (
        input  in_valid, alu_op, data1, data2,
        output in_ready, out_valid, d_out, hi, lo,
               zero_flag, exp_overflow, div_by_zero, illegal_op, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with single-cycle integer ops, signed-overflow
//               detection, and iterative radix-2 multiply / restoring divide
//               producing a HI/LO pair. One result per accepted request.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_seq_if.slave (request handshake, operands, results, flags)
// Build option: define ALU_DIV_EN to build the divider; otherwise DIV/DIVU
//               complete in one cycle as illegal opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_OR    = 4'd2,
                           OP_AND = 4'd3,  OP_XOR  = 4'd4,  OP_NOR   = 4'd5,
                           OP_SLT = 4'd6,  OP_SLTU = 4'd7,  OP_SLL   = 4'd8,
                           OP_SRL = 4'd9,  OP_SRA  = 4'd10, OP_MULT  = 4'd11,
                           OP_MULTU = 4'd12, OP_DIV = 4'd13, OP_DIVU = 4'd14;

    state_t state, state_next;

    logic accept, is_mul, is_div, is_signed, last_iter;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // Iteration datapath: lo_acc starts as multiplier / dividend magnitude,
    // hi_acc as partial product / partial remainder.
    logic [WIDTH-1:0]   hi_acc, lo_acc, mcand;
    logic [SHAMT_W-1:0] cnt;
    logic               neg_res, zero_st;

    assign accept    = bus.in_valid & bus.in_ready;
    assign shamt     = bus.data2[SHAMT_W-1:0];
    assign is_mul    = (bus.alu_op == OP_MULT) | (bus.alu_op == OP_MULTU);
`ifdef ALU_DIV_EN
    assign is_div    = (bus.alu_op == OP_DIV) | (bus.alu_op == OP_DIVU);
`else
    assign is_div    = 1'b0;
`endif
    assign is_signed = (bus.alu_op == OP_MULT) | (bus.alu_op == OP_DIV);
    assign a_mag     = (is_signed & bus.data1[WIDTH-1]) ? -bus.data1 : bus.data1;
    assign b_mag     = (is_signed & bus.data2[WIDTH-1]) ? -bus.data2 : bus.data2;
    assign last_iter = (cnt == SHAMT_W'(WIDTH - 1));

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == MUL) | (state == DIV);
    assign bus.out_valid = (state == DONE);

    // ---------------- single-cycle ops ----------------
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf, sc_illegal;

    always_comb begin
        sum_ext    = '0;
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                sum_ext   = {bus.data1[WIDTH-1], bus.data1} + {bus.data2[WIDTH-1], bus.data2};
                sc_result = sum_ext[WIDTH-1:0];
                sc_ovf    = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
            end
            OP_SUB: begin
                sum_ext   = {bus.data1[WIDTH-1], bus.data1} - {bus.data2[WIDTH-1], bus.data2};
                sc_result = sum_ext[WIDTH-1:0];
                sc_ovf    = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
            end
            OP_OR:   sc_result = bus.data1 | bus.data2;
            OP_AND:  sc_result = bus.data1 & bus.data2;
            OP_XOR:  sc_result = bus.data1 ^ bus.data2;
            OP_NOR:  sc_result = ~(bus.data1 | bus.data2);
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (bus.data1 < bus.data2)};
            OP_SLL:  sc_result = bus.data1 << shamt;
            OP_SRL:  sc_result = bus.data1 >> shamt;
            OP_SRA:  sc_result = $signed(bus.data1) >>> shamt;
            // Reserved opcode, and DIV/DIVU when the divider is not built.
            default: sc_illegal = 1'b1;
        endcase
    end

    // ---------------- multiply step ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_full, prod_fix;

    always_comb begin
        mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, mcand} : '0);
        // Shift the whole {carry, hi, lo} product register right by one.
        prod_full = {mul_sum, lo_acc[WIDTH-1:1]};
        prod_fix  = neg_res ? -prod_full : prod_full;
    end

`ifdef ALU_DIV_EN
    // ---------------- divide step ----------------
    logic             neg_rem;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_rem_n, div_q_n, q_fix, r_fix;

    always_comb begin
        div_trial = {hi_acc, lo_acc[WIDTH-1]} - {1'b0, mcand};
        if (!div_trial[WIDTH]) begin
            div_rem_n = div_trial[WIDTH-1:0];
            div_q_n   = {lo_acc[WIDTH-2:0], 1'b1};
        end else begin
            // Trial failed, so the shifted remainder is below the divisor and fits in WIDTH.
            div_rem_n = {hi_acc[WIDTH-2:0], lo_acc[WIDTH-1]};
            div_q_n   = {lo_acc[WIDTH-2:0], 1'b0};
        end
        q_fix = neg_res ? -div_q_n   : div_q_n;
        r_fix = neg_rem ? -div_rem_n : div_rem_n;
    end
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) begin
                if (is_mul)                          state_next = MUL;
                else if (is_div && bus.data2 != '0)  state_next = DIV;
                else                                 state_next = DONE;
            end
            MUL, DIV: if (last_iter) state_next = DONE;
            default:  state_next = IDLE;
        endcase
    end

    // ---------------- datapath and result registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_acc <= '0; lo_acc <= '0; mcand <= '0; cnt <= '0;
            neg_res <= 1'b0; zero_st <= 1'b0;
`ifdef ALU_DIV_EN
            neg_rem <= 1'b0;
`endif
            bus.d_out <= '0; bus.hi <= '0; bus.lo <= '0;
            bus.zero_flag <= 1'b0; bus.exp_overflow <= 1'b0;
            bus.div_by_zero <= 1'b0; bus.illegal_op <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    hi_acc  <= '0;
                    lo_acc  <= a_mag;
                    mcand   <= b_mag;
                    cnt     <= '0;
                    neg_res <= is_signed & (bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1]);
                    zero_st <= (bus.data1 == bus.data2);
`ifdef ALU_DIV_EN
                    neg_rem <= is_signed & bus.data1[WIDTH-1];
`endif
                    if (is_div && bus.data2 == '0) begin
                        bus.d_out <= '0; bus.hi <= bus.data1; bus.lo <= '1;
                        bus.zero_flag <= (bus.data1 == bus.data2);
                        bus.exp_overflow <= 1'b0; bus.div_by_zero <= 1'b1;
                        bus.illegal_op <= 1'b0;
                    end else if (!is_mul && !is_div) begin
                        bus.d_out <= sc_result; bus.hi <= '0; bus.lo <= '0;
                        bus.zero_flag <= (bus.data1 == bus.data2);
                        bus.exp_overflow <= sc_ovf; bus.div_by_zero <= 1'b0;
                        bus.illegal_op <= sc_illegal;
                    end
                end
                MUL: begin
                    {hi_acc, lo_acc} <= prod_full;
                    cnt <= cnt + SHAMT_W'(1);
                    if (last_iter) begin
                        bus.d_out <= '0;
                        bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
                        bus.lo <= prod_fix[WIDTH-1:0];
                        bus.zero_flag <= zero_st; bus.exp_overflow <= 1'b0;
                        bus.div_by_zero <= 1'b0; bus.illegal_op <= 1'b0;
                    end
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    hi_acc <= div_rem_n;
                    lo_acc <= div_q_n;
                    cnt <= cnt + SHAMT_W'(1);
                    if (last_iter) begin
                        bus.d_out <= '0; bus.hi <= r_fix; bus.lo <= q_fix;
                        bus.zero_flag <= zero_st; bus.exp_overflow <= 1'b0;
                        bus.div_by_zero <= 1'b0; bus.illegal_op <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=32): directed cases,
//               held-request-while-busy, mid-op reset and random operations
//               compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [31:0] d, hi, lo;
        logic        z, ovf, dbz, ill;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_seq_if #(.WIDTH(W)) bif ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model computed from the arithmetic meaning of each opcode.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e);
        longint          sa, sb, r;
        longint unsigned ua, ub, p;
        int              sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = int'(b % 32);
        e.d = '0; e.hi = '0; e.lo = '0;
        e.z = (a == b); e.ovf = 1'b0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
        case (op)
            4'd0:  begin r = sa + sb; e.d = r[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
            4'd1:  begin r = sa - sb; e.d = r[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
            4'd2:  e.d = a | b;
            4'd3:  e.d = a & b;
            4'd4:  e.d = a ^ b;
            4'd5:  e.d = ~(a | b);
            4'd6:  e.d = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  e.d = (ua < ub) ? 32'd1 : 32'd0;
            4'd8:  begin p = ua * (64'd1 << sh); e.d = p[31:0]; end
            4'd9:  begin p = ua / (64'd1 << sh); e.d = p[31:0]; end
            4'd10: begin r = sa >>> sh; e.d = r[31:0]; end
            4'd11: begin r = sa * sb; e.hi = r[63:32]; e.lo = r[31:0]; e.lat = 33; end
            4'd12: begin p = ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 33; end
`ifdef ALU_DIV_EN
            4'd13, 4'd14: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else if (op == 4'd13) begin
                    r = sa / sb; e.lo = r[31:0];   // MIN/-1 gives 2^31 -> low bits = MIN
                    r = sa % sb; e.hi = r[31:0];
                    e.lat = 33;
                end else begin
                    p = ua / ub; e.lo = p[31:0];
                    p = ua % ub; e.hi = p[31:0];
                    e.lat = 33;
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".d_out"}, {32'd0, bif.d_out}, {32'd0, e.d});
        chk({tag, ".hi"},    {32'd0, bif.hi},    {32'd0, e.hi});
        chk({tag, ".lo"},    {32'd0, bif.lo},    {32'd0, e.lo});
        chk({tag, ".flags"}, {60'd0, bif.zero_flag, bif.exp_overflow, bif.div_by_zero, bif.illegal_op},
                             {60'd0, e.z, e.ovf, e.dbz, e.ill});
    endtask

    // Issue one op, scramble inputs while it runs, then check result and hold.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n, lat, bc;
        model(op, a, b, e);
        @(negedge clk);
        bif.in_valid = 1'b1; bif.alu_op = op; bif.data1 = a; bif.data2 = b;
        n = 0;
        while (bif.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk({tag, ".in_ready"}, {63'd0, bif.in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.alu_op = 4'($urandom); bif.data1 = $urandom; bif.data2 = $urandom;
        lat = 1; bc = 0;
        while (bif.out_valid !== 1'b1 && lat < 40) begin
            if (bif.busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
        chk({tag, ".busy_cycles"}, 64'(bc), 64'(e.lat - 1));
        check_outputs(tag, e);
        @(negedge clk);
        chk({tag, ".pulse_ready"}, {62'd0, bif.out_valid, bif.in_ready}, 64'd1);
        chk({tag, ".hold"}, {bif.hi, bif.lo}, {e.hi, e.lo});
    endtask

    initial begin
        exp_t e;
        int   n;
        bit   seen;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        bif.in_valid = 1'b0; bif.alu_op = '0; bif.data1 = '0; bif.data2 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.ctrl", {61'd0, bif.in_ready, bif.out_valid, bif.busy}, 64'd4);
        e.d = '0; e.hi = '0; e.lo = '0; e.z = 0; e.ovf = 0; e.dbz = 0; e.ill = 0; e.lat = 1;
        check_outputs("reset", e);
        rst_n = 1'b1;

        // Directed cases
        do_op("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h0000_0001);
        do_op("sub_zero", 4'd1,  32'd5, 32'd5);
        do_op("sra",      4'd10, 32'h8000_0000, 32'h0000_0024);
        do_op("sltu",     4'd7,  32'hFFFF_FFFF, 32'd1);
        do_op("slt",      4'd6,  32'hFFFF_FFFF, 32'd1);
        do_op("sub_ovf",  4'd1,  32'h8000_0000, 32'd1);
        do_op("sll",      4'd8,  32'h0000_00F1, 32'hFFFF_FFE3);
        do_op("nor",      4'd5,  32'h0F0F_0000, 32'h0000_00FF);
        do_op("mult",     4'd11, 32'hFFFF_FFFD, 32'd7);
        do_op("multu",    4'd12, 32'hFFFF_FFFD, 32'd7);
        do_op("mult_min", 4'd11, 32'h8000_0000, 32'h8000_0000);
        do_op("div_neg",  4'd13, 32'hFFFF_FFF9, 32'd2);
        do_op("div_min",  4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_0",   4'd14, 32'd9, 32'd0);
        do_op("div_8_2",  4'd13, 32'd8, 32'd2);
        do_op("illegal",  4'd15, 32'd3, 32'd3);

        // Request held with a different op while busy: accepted only after IDLE
        @(negedge clk);
        bif.in_valid = 1'b1; bif.alu_op = 4'd11; bif.data1 = 32'hFFFF_FFFD; bif.data2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bif.alu_op = 4'd0; bif.data1 = 32'd10; bif.data2 = 32'd20;
        n = 1;
        while (bif.out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("held.mult_latency", 64'(n), 64'd33);
        chk("held.mult_result", {bif.hi, bif.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        chk("held.ready", {63'd0, bif.in_ready}, 64'd1);
        @(negedge clk);
        bif.in_valid = 1'b0;
        chk("held.add_valid", {63'd0, bif.out_valid}, 64'd1);
        chk("held.add_result", {32'd0, bif.d_out}, 64'd30);

        // Reset in cycle 10 of a MULT
        @(negedge clk);
        bif.in_valid = 1'b1; bif.alu_op = 4'd11; bif.data1 = 32'd3; bif.data2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset.ctrl", {61'd0, bif.in_ready, bif.out_valid, bif.busy}, 64'd4);
        e.d = '0; e.hi = '0; e.lo = '0; e.z = 0; e.ovf = 0; e.dbz = 0; e.ill = 0;
        check_outputs("midreset", e);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bif.out_valid === 1'b1) seen = 1'b1;
        end
        chk("midreset.no_valid", {63'd0, seen}, 64'd0);
        do_op("after_reset_add", 4'd0, 32'd1, 32'd2);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = rb;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the single-cycle datapath ALU. It provides single-cycle integer ops with signed-overflow detection, plus iterative multiply and divide that write a HI/LO result pair. It sits in the EX stage behind a valid/ready handshake, so the pipeline control can stall on `busy` while a multi-cycle op runs.

## Interface
- `WIDTH`, 32: operand/result width (≥4, power of two).
- `SHAMT_W`, $clog2(WIDTH): shift-amount bits taken from `data2`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high in IDLE only; accept = `in_valid & in_ready`.
- `alu_op`  in  4  opcode, see Operation.
- `data1`, `data2`  in  WIDTH  operands (rs, rt).
- `out_valid`  out  1  one-cycle pulse, result valid.
- `d_out`  out  WIDTH  single-cycle-op result (0 for mul/div).
- `hi`, `lo`  out  WIDTH  mul/div result (0 for single-cycle ops).
- `zero_flag`  out  1  registered `data1==data2` of the accepted op.
- `exp_overflow`  out  1  signed overflow, ADD/SUB only.
- `div_by_zero`  out  1  DIV/DIVU with `data2==0`.
- `illegal_op`  out  1  unsupported opcode.
- `busy`  out  1  high in MUL/DIV states.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 reserved.
- Shifts: the value is `data1`; the amount is `data2[SHAMT_W-1:0]`, with upper bits ignored.
- ADD/SUB: operands are sign-extended to WIDTH+1. `exp_overflow = sum[WIDTH]^sum[WIDTH-1]`. `d_out` is the low WIDTH bits and is written even on overflow.
- SLT/SLTU: `d_out` = {0…0, lt}.
- Opcode 15: `d_out=0`, `illegal_op=1`, completes in 1 cycle.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→DONE on accept of a single-cycle op.
  - IDLE→MUL on MULT/MULTU; IDLE→DIV on DIV/DIVU.
  - MUL/DIV→DONE after WIDTH iterations.
  - DONE→IDLE unconditionally.
- MUL: radix-2 shift-add on operand magnitudes. Signed result is negated if the operand signs differ. `{hi,lo}` is the 2·WIDTH product.
- DIV: restoring, one quotient bit per cycle on magnitudes. `lo`=quotient, `hi`=remainder.
  - Signed: quotient is negative iff the signs differ; remainder takes the sign of the dividend.
  - MIN / −1: `lo`=MIN, `hi`=0, no flag.
- Divide by zero: no iteration, goes to DONE next cycle with `hi=data1`, `lo`=all ones, `div_by_zero=1`.
- Operands, opcode and `zero_flag` are captured on accept. Input changes while busy are ignored.
- `in_valid` while not IDLE is ignored and not queued. The source holds it until `in_ready`.

## Timing
- Accept in cycle 0.
- Single-cycle ops: `out_valid` in cycle 1.
- MUL/DIV: iterations in cycles 1..WIDTH, `out_valid` in cycle WIDTH+1.
- `out_valid` coincides with DONE. `in_ready` rises the cycle after DONE, so the back-to-back issue interval is 2 cycles for single-cycle ops.
- `busy` is high exactly in MUL/DIV states.
- Result outputs and flags hold their values until the next DONE. Flags not relevant to the completed op are 0.
- No output backpressure.
- Reset (`rst_n=0` at a clock edge): state→IDLE and every output register→0, so `in_ready`=1 after the reset clock.
- Reset mid-MUL/DIV aborts with no `out_valid`.

## Configuration
- `ALU_DIV_EN` defined: DIV/DIVU are implemented as above.
- `ALU_DIV_EN` undefined: no divider logic is built. DIV/DIVU behave as opcode 15: 1-cycle, `hi=lo=0`, `illegal_op=1`, `div_by_zero=0`.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → cycle 1: `d_out`=0x80000000, `exp_overflow`=1. SUB 5−5 → `d_out`=0, `zero_flag`=1.
- SRA 0x80000000 by `data2`=0x24 (amount 4) → `d_out`=0xF8000000. SLTU 0xFFFFFFFF, 1 → `d_out`=0.
- MULT 0xFFFFFFFD (−3) × 7 → `busy` for cycles 1–32, `out_valid` at cycle 33 with `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. MULTU same operands → `hi`=0x00000006, `lo`=0xFFFFFFEB.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIVU 9/0 → cycle 1: `div_by_zero`=1, `hi`=9, `lo`=0xFFFFFFFF.
- `rst_n` low at cycle 10 of a MULT → no `out_valid`, `in_ready`=1 next cycle, all outputs 0. A following ADD 1+2 gives `d_out`=3.
- `in_valid` held with a new op during `busy` → not accepted until IDLE. Without `ALU_DIV_EN`, DIV 8/2 → cycle 1: `illegal_op`=1, `hi=lo=0`.
